// File: rtl/cond_stage.sv
// E->M boundary: NZCV flag register, condition evaluation and control gating; 1-cycle latency to M outputs, flags visible next cycle.
// No handshake: stall holds the M register and blocks flag writes, flush bubbles the M controls.
module cond_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_e,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS_e,
  input  logic             RegW_e,
  input  logic             MemW_e,
  input  logic             NoWrite_e,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    WA,
  output logic [3:0]       Flags,
  output logic             CondEx_e,
  output logic             valid_m,
  output logic             PCSrc_m,
  output logic             RegWrite_m,
  output logic             MemWrite_m,
  output logic [WIDTH-1:0] ALUOut_m,
  output logic [WIDTH-1:0] WriteData_m,
  output logic [AW-1:0]    WA_m
);

  logic [3:0] flags_q;
  logic       n, z, c, v;
  logic       cond_pass;
  logic       exec;
  logic       fl_en;

  assign {n, z, c, v} = flags_q;
  assign Flags        = flags_q;

  // Evaluated against the registered flags only; no bypass from ALUFlags.
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  assign CondEx_e = cond_pass;
  assign exec     = valid_e & cond_pass;
  // Flush intentionally does not block the flag write; only stall does.
  assign fl_en    = exec & ~stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else if (fl_en) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_m     <= 1'b0;
      PCSrc_m     <= 1'b0;
      RegWrite_m  <= 1'b0;
      MemWrite_m  <= 1'b0;
      ALUOut_m    <= '0;
      WriteData_m <= '0;
      WA_m        <= '0;
    end else if (flush) begin
      // Data fields hold; a bubble only needs its controls cleared.
      valid_m    <= 1'b0;
      PCSrc_m    <= 1'b0;
      RegWrite_m <= 1'b0;
      MemWrite_m <= 1'b0;
    end else if (!stall) begin
      valid_m     <= valid_e;
      PCSrc_m     <= exec & PCS_e;
      RegWrite_m  <= exec & RegW_e & ~NoWrite_e;
      MemWrite_m  <= exec & MemW_e;
      ALUOut_m    <= ALUResult;
      WriteData_m <= WriteData;
      WA_m        <= WA;
    end
  end

endmodule
